lutram_fifo: RTL

32-deep first-word-fall-through FIFO whose storage is a LUT-based distributed RAM: synchronous write, asynchronous read. It buffers 2-bit-sliced data words, up to 16 bits, between a producer and a consumer stage. A registered output stage gives M_DATA a flop-to-output path. Total capacity is 2**DEPTH_LOG2 + 1 words: the RAM entries plus the output register.

---
 rtl/lutram_fifo_pkg.sv | 12 +
 rtl/lutram_fifo_sdp.sv | 27 ++
 rtl/lutram_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/lutram_fifo_pkg.sv
// Shared constants and helpers for the LUT-RAM FIFO slice.
package lutram_fifo_pkg;

  // Default RAM depth exponent (32 entries).
  localparam int FIFO_DEPTH_LOG2 = 5;

  // Occupancy counters need one extra bit: RAM entries plus the output register.
  function automatic int level_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/lutram_fifo_sdp.sv
// Simple-dual-port distributed RAM: posedge write, asynchronous read, no reset.
module lutram_sdp
  import lutram_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = FIFO_DEPTH_LOG2
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] DI,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [DATA_W-1:0] DO
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: storage only, so no reset is applied.
  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[WADDR] <= DI;
    end
  end

  assign DO = mem[RADDR];

endmodule

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO: distributed RAM behind a registered output word.
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              S_VALID,
  output logic                              S_READY,
  input  logic [DATA_W-1:0]                 S_DATA,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic [DATA_W-1:0]                 M_DATA,
  output logic [level_w(DEPTH_LOG2)-1:0]    LEVEL
);

  localparam int CW = level_w(DEPTH_LOG2);
  localparam logic [CW-1:0] RAM_FULL = CW'(2**DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         ram_cnt;
  logic [CW-1:0]         ram_cnt_nxt;
  logic [DATA_W-1:0]     ram_rd_data;

  logic push;
  logic pop;
  logic load;
  logic ram_empty;
  logic bypass;
  logic refill;
  logic ram_we;

  // Handshake decode: the output word is reloaded whenever it is empty or being taken.
  always_comb begin
    push        = S_VALID & S_READY;
    pop         = M_VALID & M_READY;
    load        = ~M_VALID | M_READY;
    ram_empty   = (ram_cnt == '0);
    bypass      = load & ram_empty & push;
    refill      = load & ~ram_empty;
    ram_we      = push & ~bypass;
    ram_cnt_nxt = ram_cnt + CW'(ram_we) - CW'(refill);
  end

  lutram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .CLK   (CLK),
    .WE    (ram_we),
    .WADDR (wr_ptr),
    .DI    (S_DATA),
    .RADDR (rd_ptr),
    .DO    (ram_rd_data)
  );

  // Control state: pointers wrap naturally; S_READY looks one cycle ahead at RAM occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      M_VALID <= 1'b0;
      LEVEL   <= '0;
      S_READY <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (refill) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (load) begin
        M_VALID <= refill | push;
      end
      ram_cnt <= ram_cnt_nxt;
      LEVEL   <= LEVEL + CW'(push) - CW'(pop);
      S_READY <= (ram_cnt_nxt != RAM_FULL);
    end
  end

  // Output word: RAM head on refill, producer data directly on bypass, otherwise held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      M_DATA <= '0;
    end else if (refill) begin
      M_DATA <= ram_rd_data;
    end else if (bypass) begin
      M_DATA <= S_DATA;
    end
  end

endmodule
